// File: rtl/sprite_pkg.sv
// Shared geometry and colour constants for the sprite compositor.
package sprite_pkg;
  localparam int BG_W  = 551;
  localparam int BG_H  = 401;
  localparam int SPR_W = 47;
  localparam int SPR_H = 41;
  localparam int RGB_W = 12;

  typedef logic [RGB_W-1:0] rgb_t;

  localparam rgb_t KEY = 12'h428;
endpackage

// File: rtl/sprite_compositor_anim_ticker.sv
// Animation clock: advances anim_step once every FRAME_TICKS cycles, wrapping 15->0.
// Free-running, no backpressure.
module anim_ticker #(
  parameter int FRAME_TICKS = 2_000_000
) (
  input  logic       clk,
  input  logic       rstn,
  output logic [3:0] anim_step
);
  localparam int CW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_TICKS - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt       <= '0;
      anim_step <= 4'd0;
    end else if (cnt == LAST) begin
      cnt       <= '0;
      anim_step <= anim_step + 4'd1;
    end else begin
      cnt       <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/sprite_compositor.sv
// Per-pixel background + animated sprite overlay; pixel lags coordinates by 3 clk.
// Fully pipelined, one pixel per clk, no backpressure.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int FRAME_TICKS = 2_000_000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [9:0]  col_addr,
  input  logic [8:0]  row_addr,
  input  logic [9:0]  spr_x,
  input  logic [8:0]  spr_y,
  output logic [18:0] bg_addr,
  input  logic [11:0] bg_data,
  output logic [10:0] spr_addr,
  input  logic [11:0] spr_data0,
  input  logic [11:0] spr_data1,
  input  logic [11:0] spr_data2,
  input  logic [11:0] spr_data3,
  output logic [11:0] pixel,
  output logic [3:0]  anim_step
);
  logic        bg_in_c, spr_in_c;
  logic        bg_in_s1, spr_in_s1, bg_in_s2, spr_in_s2;
  logic [10:0] col_e, row_e, spr_x_e, spr_y_e, spr_x_end, spr_y_end;
  logic [9:0]  dx;
  logic [8:0]  dy;
  rgb_t        spr_sel;

  anim_ticker #(.FRAME_TICKS(FRAME_TICKS)) u_ticker (
    .clk       (clk),
    .rstn      (rstn),
    .anim_step (anim_step)
  );

  // Bounds are compared at 11 bits so a sprite near column 1023 cannot wrap onto column 0.
  assign col_e     = {1'b0, col_addr};
  assign row_e     = {2'b0, row_addr};
  assign spr_x_e   = {1'b0, spr_x};
  assign spr_y_e   = {2'b0, spr_y};
  assign spr_x_end = spr_x_e + 11'(SPR_W - 1);
  assign spr_y_end = spr_y_e + 11'(SPR_H - 1);

  assign bg_in_c  = (col_addr < 10'(BG_W)) && (row_addr < 9'(BG_H));
  assign spr_in_c = (col_e >= spr_x_e) && (col_e <= spr_x_end) &&
                    (row_e >= spr_y_e) && (row_e <= spr_y_end);
  assign dx = col_addr - spr_x;
  assign dy = row_addr - spr_y;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bg_addr   <= '0;
      spr_addr  <= '0;
      bg_in_s1  <= 1'b0;
      spr_in_s1 <= 1'b0;
      bg_in_s2  <= 1'b0;
      spr_in_s2 <= 1'b0;
      pixel     <= '0;
    end else begin
      bg_addr   <= bg_in_c ? (19'(row_addr) * 19'(BG_W) + 19'(col_addr)) : 19'd0;
      spr_addr  <= spr_in_c ? (11'(dy) * 11'(SPR_W) + 11'(dx)) : 11'd0;
      bg_in_s1  <= bg_in_c;
      spr_in_s1 <= spr_in_c;
      bg_in_s2  <= bg_in_s1;
      spr_in_s2 <= spr_in_s1;
      if (spr_in_s2 && spr_sel != KEY)
        pixel <= spr_sel;
      else if (bg_in_s2)
        pixel <= bg_data;
      else
        pixel <= 12'h000;
    end
  end

  always_comb begin
    spr_sel = spr_data0;
    case (anim_step[3:2])
      2'd0: spr_sel = spr_data0;
      2'd1: spr_sel = spr_data1;
      2'd2: spr_sel = spr_data2;
      2'd3: spr_sel = spr_data3;
      default: spr_sel = spr_data0;
    endcase
  end
endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor with FRAME_TICKS=4 and registered ROM models.
module tb_sprite_compositor;
  logic        clk = 1'b0;
  logic        rstn;
  logic [9:0]  col_addr, spr_x;
  logic [8:0]  row_addr, spr_y;
  logic [18:0] bg_addr;
  logic [10:0] spr_addr;
  logic [11:0] bg_data, spr_data0, spr_data1, spr_data2, spr_data3;
  logic [11:0] pixel;
  logic [3:0]  anim_step;

  logic [11:0] bg_val;
  logic [11:0] pose_val [4];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // ROM models with one-cycle read latency
  always @(posedge clk) begin
    bg_data   <= bg_val;
    spr_data0 <= pose_val[0];
    spr_data1 <= pose_val[1];
    spr_data2 <= pose_val[2];
    spr_data3 <= pose_val[3];
  end

  sprite_compositor #(.FRAME_TICKS(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .col_addr  (col_addr),
    .row_addr  (row_addr),
    .spr_x     (spr_x),
    .spr_y     (spr_y),
    .bg_addr   (bg_addr),
    .bg_data   (bg_data),
    .spr_addr  (spr_addr),
    .spr_data0 (spr_data0),
    .spr_data1 (spr_data1),
    .spr_data2 (spr_data2),
    .spr_data3 (spr_data3),
    .pixel     (pixel),
    .anim_step (anim_step)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_poses(input logic [11:0] p0, input logic [11:0] p1,
                           input logic [11:0] p2, input logic [11:0] p3);
    pose_val[0] = p0;
    pose_val[1] = p1;
    pose_val[2] = p2;
    pose_val[3] = p3;
  endtask

  task automatic set_pos(input logic [9:0] c, input logic [8:0] r);
    col_addr = c;
    row_addr = r;
  endtask

  initial begin
    rstn   = 1'b0;
    spr_x  = 10'd100;
    spr_y  = 9'd50;
    bg_val = 12'hABC;
    set_poses(12'h0F0, 12'h0F0, 12'h0F0, 12'h0F0);
    set_pos(10'd0, 9'd0);
    tick(2);
    chk("rst_pixel", pixel, 12'h000);
    chk("rst_step", anim_step, 4'd0);
    chk("rst_bg_addr", bg_addr, 19'd0);
    chk("rst_spr_addr", spr_addr, 11'd0);
    rstn = 1'b1;

    // Background path
    set_pos(10'd10, 9'd2);
    tick(1);
    chk("bg_addr_10_2", bg_addr, 19'd1112);
    chk("spr_addr_outside", spr_addr, 11'd0);
    tick(2);
    chk("bg_pixel", pixel, 12'hABC);

    // Sprite bottom-right corner and one column past it
    set_pos(10'd146, 9'd90);
    tick(1);
    chk("spr_addr_corner", spr_addr, 11'd1926);
    tick(2);
    chk("spr_pixel_corner", pixel, 12'h0F0);
    set_pos(10'd147, 9'd90);
    tick(1);
    chk("spr_addr_past", spr_addr, 11'd0);
    chk("bg_addr_147_90", bg_addr, 19'd49737);
    tick(2);
    chk("bg_pixel_past", pixel, 12'hABC);

    // Top-left corner and the column before it
    set_pos(10'd100, 9'd50);
    tick(3);
    chk("spr_pixel_tl", pixel, 12'h0F0);
    set_pos(10'd99, 9'd50);
    tick(3);
    chk("bg_pixel_left", pixel, 12'hABC);

    // Transparent key shows background
    set_poses(12'h428, 12'h428, 12'h428, 12'h428);
    bg_val = 12'h123;
    set_pos(10'd120, 9'd60);
    tick(3);
    chk("key_transparent", pixel, 12'h123);

    // Background bounds
    set_poses(12'h0F0, 12'h0F0, 12'h0F0, 12'h0F0);
    set_pos(10'd551, 9'd0);
    tick(1);
    chk("bg_addr_col551", bg_addr, 19'd0);
    tick(2);
    chk("pixel_col551", pixel, 12'h000);
    set_pos(10'd550, 9'd400);
    tick(1);
    chk("bg_addr_last", bg_addr, 19'd220950);
    set_pos(10'd0, 9'd401);
    tick(1);
    chk("bg_addr_row401", bg_addr, 19'd0);

    // Sprite near column 1023 must not wrap to low columns
    spr_x = 10'd1000;
    spr_y = 9'd0;
    set_pos(10'd5, 9'd10);
    tick(1);
    chk("nowrap_spr_addr", spr_addr, 11'd0);
    tick(2);
    chk("nowrap_pixel", pixel, 12'h123);
    set_pos(10'd1010, 9'd10);
    tick(1);
    chk("far_spr_addr", spr_addr, 11'd480);
    tick(2);
    chk("far_spr_pixel", pixel, 12'h0F0);

    // Reset mid-run is immediate
    rstn = 1'b0;
    #1;
    chk("midrst_pixel", pixel, 12'h000);
    chk("midrst_step", anim_step, 4'd0);
    chk("midrst_bg_addr", bg_addr, 19'd0);
    chk("midrst_spr_addr", spr_addr, 11'd0);

    // Animation: pose selection follows anim_step[3:2]
    spr_x  = 10'd100;
    spr_y  = 9'd50;
    bg_val = 12'h000;
    set_poses(12'h111, 12'h222, 12'h333, 12'h444);
    set_pos(10'd120, 9'd60);
    tick(2);
    rstn = 1'b1;
    tick(3);
    chk("anim_step_3", anim_step, 4'd0);
    tick(1);
    chk("anim_step_4", anim_step, 4'd1);
    tick(16);
    chk("anim_step_20", anim_step, 4'd5);
    chk("pose1_pixel", pixel, 12'h222);
    tick(32);
    chk("anim_step_52", anim_step, 4'd13);
    chk("pose3_pixel", pixel, 12'h444);
    tick(8);
    chk("anim_step_60", anim_step, 4'd15);
    tick(4);
    chk("anim_wrap_64", anim_step, 4'd0);
    chk("pose3_pixel_64", pixel, 12'h444);
    tick(4);
    chk("anim_step_68", anim_step, 4'd1);
    chk("pose0_pixel_68", pixel, 12'h111);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
